// File: rtl/poc_fetch_unit.sv
// poc_fetch_unit
// Fetch engine that owns PC, IAR (imem_addr) and IDR (instr). It walks the
// instruction RAM one or two words at a time and hands each assembled
// instruction to decode over a valid/ready handshake. A branch redirect
// re-targets the PC from any state and drops whatever is in flight.

module poc_fetch_unit #(
    parameter int W        = 9,   // instruction word width
    parameter int AW       = 9,   // instruction address width
    parameter int MEM_LAT  = 1,   // IRAM read latency, 1..7 (1 = combinational)
    parameter int RESET_PC = 0,   // PC after reset
    parameter int LONG_EN  = 1    // 1: word0 MSB marks a two-word instruction
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            redirect,
    input  logic [AW-1:0]   redirect_pc,
    output logic [AW-1:0]   imem_addr,
    input  logic [W-1:0]    imem_rdata,
    output logic [2*W-1:0]  instr,
    output logic            instr_len,
    output logic [AW-1:0]   instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [AW-1:0]   pc_out,
    output logic            busy
);

    // Sequencer states. WAIT1 collects word0, WAIT2 collects word1 of a
    // long instruction; VALID holds the assembled instruction for decode.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT1 = 3'd2,
        S_WAIT2 = 3'd3,
        S_VALID = 3'd4
    } state_t;

    localparam logic [2:0]    LAT    = 3'(MEM_LAT);
    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);
    localparam logic [AW-1:0] ONE    = AW'(1);

    state_t           r_state;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_iar;
    logic [2:0]       r_cnt;
    logic [W-1:0]     r_word0;
    logic [2*W-1:0]   r_instr;
    logic             r_len;
    logic [AW-1:0]    r_instr_pc;
    logic             r_valid;
    logic             r_busy;

    // The read data is sampled on the MEM_LAT-th edge after the IAR moved;
    // the counter is loaded with MEM_LAT and the sample happens when it
    // reads one, so MEM_LAT=1 samples on the very next edge.
    logic             w_sample;
    logic             w_long;

    assign w_sample = (r_cnt == 3'd1);
    assign w_long   = (LONG_EN != 0) && imem_rdata[W-1];

    // FETCH sequencer: owns every architectural register of the unit.
    // NOTE: all state here is assigned with <= so every register samples the
    // pre-edge value of its neighbours; a blocking = would let e.g. r_pc+1
    // leak into r_iar within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RST_PC;
            r_iar      <= '0;
            r_cnt      <= '0;
            r_word0    <= '0;
            r_instr    <= '0;
            r_len      <= 1'b0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else if (redirect) begin
            // Redirect beats everything but reset. A transfer that happens on
            // this same edge has already been taken by decode, so dropping
            // valid here loses nothing.
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            if (en) begin
                r_state <= S_ADDR;
                r_busy  <= 1'b1;
            end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_ADDR;
                        r_busy  <= 1'b1;
                    end
                end

                S_ADDR: begin
                    r_iar      <= r_pc;
                    r_instr_pc <= r_pc;
                    r_pc       <= r_pc + ONE;
                    r_cnt      <= LAT;
                    r_state    <= S_WAIT1;
                end

                S_WAIT1: begin
                    if (w_sample) begin
                        if (w_long) begin
                            // Two-word instruction: keep word0 and go for
                            // the next address, wrapping naturally at 2^AW.
                            r_word0 <= imem_rdata;
                            r_iar   <= r_iar + ONE;
                            r_pc    <= r_pc + ONE;
                            r_cnt   <= LAT;
                            r_state <= S_WAIT2;
                        end else begin
                            r_instr <= {{W{1'b0}}, imem_rdata};
                            r_len   <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= S_VALID;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_WAIT2: begin
                    if (w_sample) begin
                        r_instr <= {r_word0, imem_rdata};
                        r_len   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_VALID: begin
                    // Outputs stay frozen until decode takes the instruction.
                    // en only decides whether another fetch follows.
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        if (en) begin
                            r_state <= S_ADDR;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_iar;
    assign instr       = r_instr;
    assign instr_len   = r_len;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc;
    assign busy        = r_busy;

    // A stalled instruction must not change or vanish unless a redirect
    // or reset intervenes.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst || redirect)
        (instr_valid && !instr_ready) |=>
            (instr_valid && $stable(instr) && $stable(instr_pc) && $stable(instr_len))
    );

endmodule

// File: tb/tb_poc_fetch_unit.sv
// tb_poc_fetch_unit
// Bench for poc_fetch_unit. Instance A (MEM_LAT=1) is checked by a
// scoreboard fed from a transaction-level model of the instruction stream;
// instance B (MEM_LAT=3) covers the longer read latency and reset mid-fetch.

module tb_poc_fetch_unit;

    localparam int W      = 9;
    localparam int AW     = 9;
    localparam int RST_PC = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared instruction RAM contents.
    logic [W-1:0] mem [0:(1<<AW)-1];

    // ---------------- instance A: MEM_LAT = 1 ----------------
    logic            rst_a, en_a, redir_a, ready_a;
    logic [AW-1:0]   redir_pc_a, addr_a, ipc_a, pc_a;
    logic [W-1:0]    rdata_a;
    logic [2*W-1:0]  instr_a;
    logic            len_a, valid_a, busy_a;

    assign rdata_a = mem[addr_a];

    poc_fetch_unit #(.W(W), .AW(AW), .MEM_LAT(1), .RESET_PC(RST_PC), .LONG_EN(1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .redirect(redir_a), .redirect_pc(redir_pc_a),
        .imem_addr(addr_a), .imem_rdata(rdata_a), .instr(instr_a), .instr_len(len_a),
        .instr_pc(ipc_a), .instr_valid(valid_a), .instr_ready(ready_a),
        .pc_out(pc_a), .busy(busy_a)
    );

    // ---------------- instance B: MEM_LAT = 3 ----------------
    logic            rst_b, en_b, redir_b, ready_b;
    logic [AW-1:0]   redir_pc_b, addr_b, ipc_b, pc_b;
    logic [W-1:0]    rdata_b, pipe1_b, pipe2_b;
    logic [2*W-1:0]  instr_b;
    logic            len_b, valid_b, busy_b;

    // Two register stages after the array give a 3-edge address-to-sample latency.
    always @(posedge clk) begin
        pipe1_b <= mem[addr_b];
        pipe2_b <= pipe1_b;
    end
    assign rdata_b = pipe2_b;

    poc_fetch_unit #(.W(W), .AW(AW), .MEM_LAT(3), .RESET_PC(RST_PC), .LONG_EN(1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .redirect(redir_b), .redirect_pc(redir_pc_b),
        .imem_addr(addr_b), .imem_rdata(rdata_b), .instr(instr_b), .instr_len(len_b),
        .instr_pc(ipc_b), .instr_valid(valid_b), .instr_ready(ready_b),
        .pc_out(pc_b), .busy(busy_b)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2*W-1:0] instr;
        logic           len;
        logic [AW-1:0]  pc;
        logic [AW-1:0]  next_pc;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] model_pc;
    exp_t          mon_e;

    // One instruction starting at pc, straight from the ISA rule: a set MSB
    // in word0 pulls in the following word (address wraps at 2^AW).
    function automatic exp_t predict(input logic [AW-1:0] pc);
        exp_t          e;
        logic [W-1:0]  w0;
        logic [AW-1:0] pc1;
        w0  = mem[pc];
        pc1 = pc + AW'(1);
        e.pc = pc;
        if (w0[W-1]) begin
            e.instr   = {w0, mem[pc1]};
            e.len     = 1'b1;
            e.next_pc = pc + AW'(2);
        end else begin
            e.instr   = {{W{1'b0}}, w0};
            e.len     = 1'b0;
            e.next_pc = pc1;
        end
        return e;
    endfunction

    task automatic refill();
        while (exp_q.size() < 2) begin
            exp_q.push_back(predict(model_pc));
            model_pc = exp_q[$].next_pc;
        end
    endtask

    task automatic flush(input logic [AW-1:0] new_pc);
        exp_q.delete();
        model_pc = new_pc;
        refill();
    endtask

    // Monitor for instance A: inputs are stable at the falling edge, so a
    // valid&&ready seen here is the transfer the next rising edge performs.
    always @(negedge clk) begin
        if (rst_a) begin
            flush(AW'(RST_PC));
        end else begin
            if (valid_a) begin
                mon_e = exp_q[0];
                check("sb_instr",   32'(instr_a), 32'(mon_e.instr));
                check("sb_len",     32'(len_a),   32'(mon_e.len));
                check("sb_instr_pc",32'(ipc_a),   32'(mon_e.pc));
                check("sb_pc_out",  32'(pc_a),    32'(mon_e.next_pc));
                check("sb_busy",    32'(busy_a),  32'd1);
                if (ready_a) begin
                    void'(exp_q.pop_front());
                    n_xfer++;
                    refill();
                end
            end
            if (redir_a) flush(redir_pc_a);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles (rising edges) until valid is seen, bounded.
    task automatic wait_valid_a(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!valid_a && cyc < 60);
    endtask

    task automatic wait_valid_b(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!valid_b && cyc < 60);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;

        rst_a = 1'b1; en_a = 1'b1; redir_a = 1'b0; redir_pc_a = '0; ready_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b0; redir_b = 1'b0; redir_pc_b = '0; ready_b = 1'b1;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

        // 1. short instruction, latency L+2
        mem[6] = 9'h0A5;
        tick(); tick();
        check("t1_reset_valid", 32'(valid_a), 32'd0);
        check("t1_reset_pc",    32'(pc_a),    32'd6);
        check("t1_reset_addr",  32'(addr_a),  32'd0);
        check("t1_reset_busy",  32'(busy_a),  32'd0);
        rst_a = 1'b0;
        wait_valid_a(cyc);
        check("t1_latency",  32'(cyc),     32'd3);
        check("t1_instr",    32'(instr_a), 32'h000A5);
        check("t1_len",      32'(len_a),   32'd0);
        check("t1_instr_pc", 32'(ipc_a),   32'd6);
        check("t1_pc_out",   32'(pc_a),    32'd7);

        // 2. long instruction, latency 2L+2, held back by ready=0
        rst_a = 1'b1; ready_a = 1'b0;
        mem[6] = 9'h1C3; mem[7] = 9'h012; mem[8] = 9'h033;
        tick(); tick();
        rst_a = 1'b0;
        wait_valid_a(cyc);
        check("t2_latency",  32'(cyc),     32'd4);
        check("t2_instr",    32'(instr_a), 32'h38612);
        check("t2_len",      32'(len_a),   32'd1);
        check("t2_instr_pc", 32'(ipc_a),   32'd6);
        check("t2_pc_out",   32'(pc_a),    32'd8);

        // 3. stall for five cycles, then release and fetch from pc_out
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", 32'(valid_a), 32'd1);
            check("t3_hold_instr", 32'(instr_a), 32'h38612);
            check("t3_hold_pc",    32'(pc_a),    32'd8);
        end
        ready_a = 1'b1;
        tick();
        check("t3_valid_drop", 32'(valid_a), 32'd0);
        wait_valid_a(cyc);
        check("t3_next_pc",    32'(ipc_a),   32'd8);
        check("t3_next_instr", 32'(instr_a), 32'h00033);

        // 4. redirect while waiting for word1 of a long instruction
        rst_a = 1'b1;
        mem[8'h40] = 9'h021;
        tick(); tick();
        rst_a = 1'b0;
        tick(); tick(); tick();
        check("t4_busy_wait2",  32'(busy_a),  32'd1);
        check("t4_valid_wait2", 32'(valid_a), 32'd0);
        redir_a = 1'b1; redir_pc_a = 9'h040;
        tick();
        redir_a = 1'b0;
        check("t4_no_valid", 32'(valid_a), 32'd0);
        check("t4_pc_out",   32'(pc_a),    32'h040);
        wait_valid_a(cyc);
        check("t4_latency",  32'(cyc),     32'd2);
        check("t4_instr_pc", 32'(ipc_a),   32'h040);
        check("t4_instr",    32'(instr_a), 32'h00021);

        // 5. long instruction straddling the address wrap
        rst_a = 1'b1;
        mem[9'h1FF] = 9'h100; mem[0] = 9'h055;
        tick(); tick();
        rst_a = 1'b0;
        redir_a = 1'b1; redir_pc_a = 9'h1FF;
        tick();
        redir_a = 1'b0;
        wait_valid_a(cyc);
        check("t5_valid",    32'(valid_a), 32'd1);
        check("t5_instr",    32'(instr_a), 32'h20055);
        check("t5_len",      32'(len_a),   32'd1);
        check("t5_instr_pc", 32'(ipc_a),   32'h1FF);
        check("t5_pc_out",   32'(pc_a),    32'h001);

        // 6. MEM_LAT=3 latency, then reset in the middle of WAIT1
        rst_a = 1'b1;
        mem[6] = 9'h0A5;
        en_b = 1'b1; ready_b = 1'b1; rst_b = 1'b1;
        tick(); tick();
        rst_b = 1'b0;
        wait_valid_b(cyc);
        check("t6_latency",  32'(cyc),     32'd5);
        check("t6_instr",    32'(instr_b), 32'h000A5);
        check("t6_len",      32'(len_b),   32'd0);
        check("t6_instr_pc", 32'(ipc_b),   32'd6);
        check("t6_pc_out",   32'(pc_b),    32'd7);
        rst_b = 1'b1;
        tick(); tick();
        rst_b = 1'b0;
        tick(); tick(); tick();
        check("t6_busy_wait1", 32'(busy_b), 32'd1);
        check("t6_pc_wait1",   32'(pc_b),   32'd7);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("t6_rst_valid", 32'(valid_b), 32'd0);
        check("t6_rst_pc",    32'(pc_b),    32'd6);
        check("t6_rst_busy",  32'(busy_b),  32'd0);
        check("t6_rst_addr",  32'(addr_b),  32'd0);
        wait_valid_b(cyc);
        check("t6_relatency", 32'(cyc),     32'd5);
        check("t6_reinstr",   32'(instr_b), 32'h000A5);
        rst_b = 1'b1;

        // Random traffic on A against the scoreboard.
        for (int i = 0; i < (1<<AW); i++) mem[i] = W'($urandom);
        tick(); tick();
        n_xfer = 0;
        rst_a = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            en_a       = ($urandom_range(0, 9) != 0);
            ready_a    = ($urandom_range(0, 9) < 7);
            redir_a    = ($urandom_range(0, 29) == 0);
            redir_pc_a = AW'($urandom);
            rst_a      = ($urandom_range(0, 399) == 0);
            tick();
        end
        check("rand_progress", 32'(n_xfer > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
